// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter
//   Registered dual-issue arbiter for the reservation station. Each cycle it picks up to
//   two ready RS entries, scanning from a rotating priority pointer, and grants them to
//   the two issue ports. Grants are one-hot, registered and last exactly one cycle.
//   Entries granted this cycle are masked from the next selection while the RS frees them.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   req_valid    in   [p_SIZE] entry i ready to issue
//   fu1_ready    in   FU1 accepts an issue next cycle
//   fu2_ready    in   FU2 accepts an issue next cycle
//   flush        in   synchronous squash, blocks new grants
//   issue1_gnt   out  [p_SIZE] one-hot grant to FU1 (zero = no issue)
//   issue2_gnt   out  [p_SIZE] one-hot grant to FU2
//   issue1_valid out  OR of issue1_gnt
//   issue2_valid out  OR of issue2_gnt
//   load         out  [p_SIZE] issue1_gnt | issue2_gnt, used by the RS to free entries
module rs_issue_arbiter #(
  parameter int unsigned p_SIZE = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [p_SIZE-1:0] req_valid,
  input  logic              fu1_ready,
  input  logic              fu2_ready,
  input  logic              flush,
  output logic [p_SIZE-1:0] issue1_gnt,
  output logic [p_SIZE-1:0] issue2_gnt,
  output logic              issue1_valid,
  output logic              issue2_valid,
  output logic [p_SIZE-1:0] load
);

  localparam int unsigned PtrW = (p_SIZE > 1) ? $clog2(p_SIZE) : 1;

  typedef logic [PtrW-1:0] ptr_t;
  // One extra bit so ptr + offset (< 2*p_SIZE) can be wrapped by a single subtract.
  typedef logic [PtrW:0]   sum_t;

  ptr_t              ptr_q, ptr_d;
  logic [p_SIZE-1:0] gnt1_q, gnt1_d;
  logic [p_SIZE-1:0] gnt2_q, gnt2_d;

  logic [p_SIZE-1:0] eligible;
  logic              found_a, found_b;
  ptr_t              a_idx, b_idx;
  sum_t              sum;
  ptr_t              idx;

  logic              any_gnt;
  ptr_t              last_idx;

  assign issue1_gnt   = gnt1_q;
  assign issue2_gnt   = gnt2_q;
  assign issue1_valid = |gnt1_q;
  assign issue2_valid = |gnt2_q;
  assign load         = gnt1_q | gnt2_q;

  // Rotating scan: first and second eligible entries starting at ptr_q.
  always_comb begin
    eligible = req_valid & ~load & {p_SIZE{~flush}};
    found_a  = 1'b0;
    found_b  = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    sum      = '0;
    idx      = '0;
    for (int unsigned k = 0; k < p_SIZE; k++) begin
      sum = {1'b0, ptr_q} + sum_t'(k);
      if (sum >= sum_t'(p_SIZE)) begin
        sum = sum - sum_t'(p_SIZE);
      end
      idx = sum[PtrW-1:0];
      if (eligible[idx]) begin
        if (!found_a) begin
          found_a = 1'b1;
          a_idx   = idx;
        end else if (!found_b) begin
          found_b = 1'b1;
          b_idx   = idx;
        end
      end
    end
  end

  // Port assignment and pointer advance past the last granted entry.
  always_comb begin
    gnt1_d   = '0;
    gnt2_d   = '0;
    any_gnt  = 1'b0;
    last_idx = a_idx;
    ptr_d    = ptr_q;

    if (fu1_ready && fu2_ready) begin
      if (found_a) begin
        gnt1_d[a_idx] = 1'b1;
        any_gnt       = 1'b1;
      end
      if (found_b) begin
        gnt2_d[b_idx] = 1'b1;
        last_idx      = b_idx;
      end
    end else if (fu1_ready) begin
      if (found_a) begin
        gnt1_d[a_idx] = 1'b1;
        any_gnt       = 1'b1;
      end
    end else if (fu2_ready) begin
      // With only FU2 ready the first candidate goes to FU2.
      if (found_a) begin
        gnt2_d[a_idx] = 1'b1;
        any_gnt       = 1'b1;
      end
    end

    if (any_gnt) begin
      ptr_d = (last_idx == ptr_t'(p_SIZE - 1)) ? '0 : last_idx + ptr_t'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      gnt1_q <= '0;
      gnt2_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      gnt1_q <= gnt1_d;
      gnt2_q <= gnt2_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_arbiter.sv
module tb_rs_issue_arbiter;

  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid;
  logic         fu1_ready;
  logic         fu2_ready;
  logic         flush;
  logic [N-1:0] issue1_gnt;
  logic [N-1:0] issue2_gnt;
  logic         issue1_valid;
  logic         issue2_valid;
  logic [N-1:0] load;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int           m_ptr;
  logic [N-1:0] m_g1;
  logic [N-1:0] m_g2;

  rs_issue_arbiter #(.p_SIZE(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .fu1_ready   (fu1_ready),
    .fu2_ready   (fu2_ready),
    .flush       (flush),
    .issue1_gnt  (issue1_gnt),
    .issue2_gnt  (issue2_gnt),
    .issue1_valid(issue1_valid),
    .issue2_valid(issue2_valid),
    .load        (load)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] e1, input logic [N-1:0] e2);
    n_checks++;
    assert (issue1_gnt === e1) else begin
      n_fail++;
      $error("FAIL %s issue1_gnt: observed %b expected %b", tag, issue1_gnt, e1);
    end
    n_checks++;
    assert (issue2_gnt === e2) else begin
      n_fail++;
      $error("FAIL %s issue2_gnt: observed %b expected %b", tag, issue2_gnt, e2);
    end
    n_checks++;
    assert (issue1_valid === (|e1)) else begin
      n_fail++;
      $error("FAIL %s issue1_valid: observed %b expected %b", tag, issue1_valid, |e1);
    end
    n_checks++;
    assert (issue2_valid === (|e2)) else begin
      n_fail++;
      $error("FAIL %s issue2_valid: observed %b expected %b", tag, issue2_valid, |e2);
    end
    n_checks++;
    assert (load === (e1 | e2)) else begin
      n_fail++;
      $error("FAIL %s load: observed %b expected %b", tag, load, e1 | e2);
    end
  endtask

  // List eligible entries in rotating order, hand them out to the ready ports.
  task automatic model_step(input logic [N-1:0] req, input logic f1, input logic f2,
                            input logic fl);
    int           cand[$];
    logic [N-1:0] elig;
    logic [N-1:0] n1;
    logic [N-1:0] n2;
    int           last;
    int           pick;
    elig = fl ? '0 : (req & ~(m_g1 | m_g2));
    for (int k = 0; k < N; k++) begin
      if (elig[(m_ptr + k) % N]) cand.push_back((m_ptr + k) % N);
    end
    n1   = '0;
    n2   = '0;
    last = -1;
    if (f1 && cand.size() > 0) begin
      n1[cand[0]] = 1'b1;
      last        = cand[0];
    end
    if (f2) begin
      pick = f1 ? 1 : 0;
      if (cand.size() > pick) begin
        n2[cand[pick]] = 1'b1;
        last           = cand[pick];
      end
    end
    if (last >= 0) m_ptr = (last + 1) % N;
    m_g1 = n1;
    m_g2 = n2;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    fu1_ready = 1'b1;
    fu2_ready = 1'b1;
    flush     = 1'b0;

    #12;
    check("reset_hold", 8'h00, 8'h00);
    reset = 1'b0;

    // Get a grant up, then reset asynchronously mid-cycle.
    req_valid = 8'b0000_0001;
    tick();
    check("pre_reset", 8'b0000_0001, 8'h00);
    #2 reset = 1'b1;
    #1;
    check("async_reset", 8'h00, 8'h00);
    #3 reset = 1'b0;
    req_valid = '0;
    tick();
    check("post_reset_idle", 8'h00, 8'h00);

    // Dual issue from ptr 0
    req_valid = 8'b0001_0110;
    tick();
    check("dual_issue", 8'b0000_0010, 8'b0000_0100);

    // Back-to-back masking, ptr 3 -> 5
    tick();
    check("masking", 8'b0001_0000, 8'h00);

    // Move ptr to 6
    req_valid = 8'b0010_0000;
    tick();
    check("to_ptr6", 8'b0010_0000, 8'h00);

    // Wrap-around, ptr 6 -> 1
    req_valid = 8'b1000_0001;
    tick();
    check("wrap", 8'b1000_0000, 8'b0000_0001);

    req_valid = '0;
    tick();
    check("empty_hold", 8'h00, 8'h00);
    // Scan from ptr 1 reaches entry 7, ptr -> 0
    req_valid = 8'b1000_0000;
    tick();
    check("to_ptr0", 8'b1000_0000, 8'h00);
    req_valid = '0;
    tick();

    // Only FU2 ready
    fu1_ready = 1'b0;
    req_valid = 8'b0000_1100;
    tick();
    check("fu2_only", 8'h00, 8'b0000_0100);

    // ptr 3: scan wraps to entry 1, ptr -> 2
    fu1_ready = 1'b1;
    req_valid = '0;
    tick();
    req_valid = 8'b0000_0010;
    tick();
    check("to_ptr2", 8'b0000_0010, 8'h00);

    // Flush blocks grants, keeps ptr
    flush     = 1'b1;
    req_valid = 8'hff;
    tick();
    check("flush", 8'h00, 8'h00);
    flush = 1'b0;
    tick();
    check("after_flush", 8'b0000_0100, 8'b0000_1000);

    // ptr should be 4 now
    req_valid = '0;
    tick();
    req_valid = 8'b0001_0001;
    tick();
    check("ptr4_order", 8'b0001_0000, 8'b0000_0001);

    // Single candidate, both ready -> FU1
    req_valid = '0;
    tick();
    req_valid = 8'b0100_0000;
    tick();
    check("single_cand", 8'b0100_0000, 8'h00);

    // Neither FU ready
    fu1_ready = 1'b0;
    fu2_ready = 1'b0;
    req_valid = 8'hff;
    tick();
    check("none_ready", 8'h00, 8'h00);

    // Randomized phase against the reference model
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    m_ptr = 0;
    m_g1  = '0;
    m_g2  = '0;
    for (int i = 0; i < 400; i++) begin
      if (i % 2 == 0) req_valid = N'($urandom);
      else req_valid = N'($urandom & $urandom);
      fu1_ready = ($urandom_range(0, 3) != 0);
      fu2_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      model_step(req_valid, fu1_ready, fu2_ready, flush);
      tick();
      check("random", m_g1, m_g2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
